// File: rtl/issue_bru_queue.sv
// -----------------------------------------------------------------------------
// issue_bru_queue_pkg / issue_bru_queue
//
// Queue of issued branch-unit ops between the issue stage and the BRU execute
// stage. Circular buffer of DEPTH entries with wrap-bit pointers; the head is
// read combinationally, and a commit-time flush empties the queue in one cycle.
//
// Optional feature macro: ISSUE_BRU_QUEUE_BYPASS_EN
//   When defined, a push into an empty queue is presented at data_out in the
//   same cycle. If that op is also popped, it is consumed without touching
//   storage or pointers. full/count are unaffected by the bypass.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active-low
//   data_in        in   op from issue
//   push           in   write request (accepted when !full && !flush)
//   full           out  no free entry
//   data_out       out  head entry
//   data_out_valid out  head entry present
//   pop            in   consume head (accepted when valid && !flush)
//   flush          in   clear all in-flight ops at the next edge
//   count          out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
package issue_bru_queue_pkg;
  typedef struct packed {
    logic        enable;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [31:0] imm;
    logic [4:0]  rob_id;
  } issue_execute_pack_t;
endpackage

module issue_bru_queue
  import issue_bru_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  issue_execute_pack_t data_in,
  input  logic                push,
  output logic                full,
  output issue_execute_pack_t data_out,
  output logic                data_out_valid,
  input  logic                pop,
  input  logic                flush,
  output logic [PTR_W:0]      count
);

  issue_execute_pack_t mem_q [DEPTH];
  logic [PTR_W:0]      rptr_q, rptr_d;
  logic [PTR_W:0]      wptr_q, wptr_d;

  logic empty;
  logic push_ok;
  logic pop_ok;
  logic do_write;
  logic do_read;

  assign empty = (rptr_q == wptr_q);
  assign full  = (rptr_q[PTR_W-1:0] == wptr_q[PTR_W-1:0]) &&
                 (rptr_q[PTR_W] != wptr_q[PTR_W]);
  assign count = wptr_q - rptr_q;

  assign push_ok = push && !full && !flush;

`ifdef ISSUE_BRU_QUEUE_BYPASS_EN
  logic bypass;
  logic consume_direct;

  // Bypass only ever fires on an empty queue, so it never depends on pop.
  assign bypass         = empty && push_ok;
  assign data_out       = bypass ? data_in : mem_q[rptr_q[PTR_W-1:0]];
  assign data_out_valid = !empty || bypass;
  assign pop_ok         = pop && data_out_valid && !flush;
  // A bypassed op that is popped at once never lands in storage.
  assign consume_direct = bypass && pop_ok;
  assign do_write       = push_ok && !consume_direct;
  assign do_read        = pop_ok && !consume_direct;
`else
  assign data_out       = mem_q[rptr_q[PTR_W-1:0]];
  assign data_out_valid = !empty;
  assign pop_ok         = pop && data_out_valid && !flush;
  assign do_write       = push_ok;
  assign do_read        = pop_ok;
`endif

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    if (flush) begin
      rptr_d = '0;
      wptr_d = '0;
    end else begin
      if (do_write) wptr_d = wptr_q + 1'b1;
      if (do_read)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  // Entry storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wptr_q[PTR_W-1:0]] <= data_in;
  end

endmodule
